// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Shares the single CDB toward the ROB between NUM_UNITS execute units.
//   Picks one finished unit per cycle round-robin, answers it with a
//   one-cycle canGo pulse and registers its result onto the CDB.
//   Optional build macro ARB_PERF_CNT_EN adds per-unit grant counters and
//   a stall counter as extra output ports.
//
// Handshake: the CDB word is transferred on a clock edge where
// cdbValid_o=1 and cdbReady_i=1; while cdbValid_o=1 and cdbReady_i=0 the
// word and every cdb*_o output stay stable.  Unit side: unitValid_i[k]=1
// means unit k holds a result, unitCanGo_o[k]=1 means that result is
// taken on this edge.

module writeback_arbiter #(
    parameter int NUM_UNITS  = 3,
    parameter int ROBsize    = 8,
    parameter int ROBsizeLog = $clog2(ROBsize + 1),
    parameter int UNITW      = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [NUM_UNITS-1:0]          unitValid_i,
    input  logic [NUM_UNITS*64-1:0]       unitVal_i,
    input  logic [NUM_UNITS*10-1:0]       unitCommands_i,
    input  logic [NUM_UNITS*ROBsizeLog-1:0] unitTag_i,
    input  logic [NUM_UNITS*4-1:0]        unitFlags_i,
    output logic [NUM_UNITS-1:0]          unitCanGo_o,
    input  logic                          cdbReady_i,
    output logic                          cdbValid_o,
    output logic [63:0]                   cdbVal_o,
    output logic [9:0]                    cdbCommands_o,
    output logic [ROBsizeLog-1:0]         cdbTag_o,
    output logic [3:0]                    cdbFlags_o,
    output logic [UNITW-1:0]              cdbUnit_o,
    output logic                          dbgState_o
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [NUM_UNITS*16-1:0]       grantCount_o,
    output logic [15:0]                   stallCount_o
`endif
);

    typedef enum logic {
        eEmpty = 1'b0,
        eFull  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [UNITW-1:0] ptr_q;
    logic             accept;
    logic             grant_any;
    logic [UNITW-1:0] grant_idx;

    // A new word may be loaded when the CDB is empty or being drained now.
    assign accept = ~reset_i & (~cdbValid_o | cdbReady_i);

    // Round-robin search starting at ptr_q; first requester wins.
    always_comb begin : grant_comb
        int idx;
        idx         = 0;
        grant_any   = 1'b0;
        grant_idx   = '0;
        unitCanGo_o = '0;
        if (accept) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
                if (!grant_any && unitValid_i[idx]) begin
                    grant_any = 1'b1;
                    grant_idx = UNITW'(idx);
                end
            end
        end
        if (grant_any) unitCanGo_o[grant_idx] = 1'b1;
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= eEmpty;
        else         state_q <= state_d;
    end

    // Next state: load on grant, drain when the ROB takes the word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            eEmpty:  if (grant_any) state_d = eFull;
            eFull:   if (cdbReady_i && !grant_any) state_d = eEmpty;
            default: state_d = eEmpty;
        endcase
    end

    // FSM outputs.
    always_comb begin
        cdbValid_o = (state_q == eFull);
        dbgState_o = state_q;
    end

    // CDB payload and round-robin pointer; both move only on a grant.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cdbVal_o      <= '0;
            cdbCommands_o <= '0;
            cdbTag_o      <= '0;
            cdbFlags_o    <= '0;
            cdbUnit_o     <= '0;
            ptr_q         <= '0;
        end else if (grant_any) begin
            cdbVal_o      <= unitVal_i[int'(grant_idx)*64 +: 64];
            cdbCommands_o <= unitCommands_i[int'(grant_idx)*10 +: 10];
            cdbTag_o      <= unitTag_i[int'(grant_idx)*ROBsizeLog +: ROBsizeLog];
            cdbFlags_o    <= unitFlags_i[int'(grant_idx)*4 +: 4];
            cdbUnit_o     <= grant_idx;
            ptr_q         <= (grant_idx == UNITW'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

`ifdef ARB_PERF_CNT_EN
    // Saturating grant and stall counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            grantCount_o <= '0;
            stallCount_o <= '0;
        end else begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                if (unitCanGo_o[k] && grantCount_o[k*16 +: 16] != 16'hFFFF)
                    grantCount_o[k*16 +: 16] <= grantCount_o[k*16 +: 16] + 16'd1;
            end
            if ((|unitValid_i) && !grant_any && stallCount_o != 16'hFFFF)
                stallCount_o <= stallCount_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter
//   Directed bench for writeback_arbiter (3 units, 4-bit tags).  Expected
//   CDB words are queued when a grant is expected and compared when the
//   word appears on the CDB.  Build with ARB_PERF_CNT_EN to cover the
//   counters as well.

module tb_writeback_arbiter;
    localparam int N  = 3;
    localparam int TW = 4;
    localparam int W  = 84;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    u_valid = '0;
    logic [N*64-1:0] u_val = '0;
    logic [N*10-1:0] u_cmd = '0;
    logic [N*TW-1:0] u_tag = '0;
    logic [N*4-1:0]  u_flags = '0;
    logic [N-1:0]    can_go;
    logic            cdb_ready = 1'b1;
    logic            cdb_valid;
    logic [63:0]     cdb_val;
    logic [9:0]      cdb_cmd;
    logic [TW-1:0]   cdb_tag;
    logic [3:0]      cdb_flags;
    logic [1:0]      cdb_unit;
    logic            dbg_state;
`ifdef ARB_PERF_CNT_EN
    logic [N*16-1:0] grant_count;
    logic [15:0]     stall_count;
`endif

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    writeback_arbiter #(.NUM_UNITS(N), .ROBsize(8)) dut (
        .clk_i(clk), .reset_i(reset),
        .unitValid_i(u_valid), .unitVal_i(u_val), .unitCommands_i(u_cmd),
        .unitTag_i(u_tag), .unitFlags_i(u_flags), .unitCanGo_o(can_go),
        .cdbReady_i(cdb_ready), .cdbValid_o(cdb_valid), .cdbVal_o(cdb_val),
        .cdbCommands_o(cdb_cmd), .cdbTag_o(cdb_tag), .cdbFlags_o(cdb_flags),
        .cdbUnit_o(cdb_unit), .dbgState_o(dbg_state)
`ifdef ARB_PERF_CNT_EN
        , .grantCount_o(grant_count), .stallCount_o(stall_count)
`endif
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver tasks
    task automatic set_unit(input int k, input logic [63:0] v, input logic [TW-1:0] t,
                            input logic [9:0] c, input logic [3:0] f);
        u_val[k*64 +: 64]  = v;
        u_tag[k*TW +: TW]  = t;
        u_cmd[k*10 +: 10]  = c;
        u_flags[k*4 +: 4]  = f;
    endtask

    function automatic logic [W-1:0] word_of(input int k);
        logic [1:0] ku;
        ku = 2'(k);
        return {ku, u_flags[k*4 +: 4], u_cmd[k*10 +: 10], u_tag[k*TW +: TW], u_val[k*64 +: 64]};
    endfunction

    function automatic logic [W-1:0] cdb_word();
        return {cdb_unit, cdb_flags, cdb_cmd, cdb_tag, cdb_val};
    endfunction

    // Scoreboard
    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_grant(input string tag, input logic [N-1:0] exp_go, input int k);
        check(tag, W'(can_go), W'(exp_go));
        if (exp_go != '0) exp_q.push_back(word_of(k));
    endtask

    task automatic expect_pop(input string tag, output logic [W-1:0] popped);
        check({tag, "_valid"}, W'(cdb_valid), W'(1'b1));
        popped = '0;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, W'(0), W'(1));
        end else begin
            popped = exp_q.pop_front();
            check(tag, cdb_word(), popped);
        end
    endtask

    initial begin
        logic [W-1:0] held;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        check("rst_valid", W'(cdb_valid), W'(0));
        check("rst_cango", W'(can_go), W'(0));
        check("rst_word", cdb_word(), W'(0));
        check("rst_state", W'(dbg_state), W'(0));
        tick();
        reset = 1'b0;

        // Single requester, unit 1
        set_unit(1, 64'hDEAD_BEEF, 4'd5, 10'h155, 4'hA);
        u_valid = 3'b010;
        @(negedge clk);
        expect_grant("single_go", 3'b010, 1);
        tick();
        u_valid = 3'b000;
        @(negedge clk);
        expect_pop("single_word", held);
        check("single_idle_go", W'(can_go), W'(0));
        tick();
        @(negedge clk);
        check("drain_empty", W'(cdb_valid), W'(0));
        tick();

        // Pointer at 2: wraps to unit 0, then moves to 1
        set_unit(0, 64'h0123_4567_89AB_CDEF, 4'd2, 10'h0F0, 4'h3);
        set_unit(1, 64'h1111_2222_3333_4444, 4'd7, 10'h3C3, 4'h5);
        u_valid = 3'b011;
        @(negedge clk);
        expect_grant("wrap_go0", 3'b001, 0);
        tick();
        @(negedge clk);
        expect_pop("wrap_word0", held);
        expect_grant("wrap_ptr1", 3'b010, 1);
        tick();
        u_valid = 3'b000;
        @(negedge clk);
        expect_pop("wrap_word1", held);
        tick();

        // Mid-traffic reset drops the held word and resets the pointer
        set_unit(2, 64'hCAFE_F00D_0000_0002, 4'd8, 10'h2AA, 4'hC);
        u_valid = 3'b111;
        @(negedge clk);
        expect_grant("pre_rst_go", 3'b100, 2);
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("mid_rst_valid", W'(cdb_valid), W'(0));
        check("mid_rst_cango", W'(can_go), W'(0));
        tick();
        reset = 1'b0;
        exp_q.delete();

        // All valid: 001, 010, 100, 001
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) expect_pop("rr_word", held);
            expect_grant("rr_go", 3'(1 << (i % 3)), i % 3);
            tick();
        end

        // Backpressure: word held stable, no grant, then no-bubble resume
        cdb_ready = 1'b0;
        u_valid   = 3'b001;
        set_unit(0, 64'hFEED_FACE_5555_AAAA, 4'd1, 10'h001, 4'h9);
        @(negedge clk);
        expect_pop("bp_word", held);
        check("bp_go0", W'(can_go), W'(0));
        for (int c = 0; c < 5; c++) begin
            tick();
            @(negedge clk);
            check("bp_hold_go", W'(can_go), W'(0));
            check("bp_hold_valid", W'(cdb_valid), W'(1));
            check("bp_hold_word", cdb_word(), held);
        end
        cdb_ready = 1'b1;
        #1;
        expect_grant("bp_resume_go", 3'b001, 0);
        tick();
        u_valid = 3'b000;
        @(negedge clk);
        expect_pop("bp_new_word", held);
        tick();

`ifdef ARB_PERF_CNT_EN
        // Counters: 3 grants to unit 2, then 4 blocked cycles
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        u_valid = 3'b100;
        tick();
        tick();
        tick();
        cdb_ready = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        u_valid = 3'b000;
        @(negedge clk);
        check("perf_grant2", W'(grant_count[2*16 +: 16]), W'(3));
        check("perf_grant01", W'(grant_count[31:0]), W'(0));
        check("perf_stall", W'(stall_count), W'(4));
        cdb_ready = 1'b1;
        tick();
`endif

        // Final report
        check("queue_empty", W'(exp_q.size()), W'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
